// File: rtl/game_sequencer.sv
// game_sequencer: turn and board controller for a 3x3 tic-tac-toe display.
// A one-hot switch selection is confirmed by a rising edge on button. The move is
// validated, committed for the current player, checked for a win or draw, and then
// the turn passes. All outputs are registered.
// Optional feature: define GAME_SEQ_TIMEOUT_EN to forfeit the turn after
// TIMEOUT_CYCLES idle cycles without a press.
module game_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        button,
   input  logic [8:0]  switches,
   output logic [17:0] board,
   output logic        turn,
   output logic [1:0]  status,
   output logic [7:0]  win_line,
   output logic [3:0]  move_count,
   output logic        move_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      st_idle,
      st_validate,
      st_commit,
      st_check,
      st_over
   } state_t;

   state_t      state_q, state_d;
   logic        btn_q;
   logic        press;
   logic [8:0]  sel_q, sel_d;
   logic [17:0] board_q, board_d;
   logic        turn_q, turn_d;
   logic [1:0]  status_q, status_d;
   logic [7:0]  win_q, win_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        err_d;
   logic        busy_q, busy_d;

   logic [8:0]  occupied;
   logic [8:0]  owned;
   logic [7:0]  lines;
   logic [1:0]  mark;
   logic        sel_valid;

`ifdef GAME_SEQ_TIMEOUT_EN
   logic [31:0] tmo_q, tmo_d;
   logic        tmo_expired;
   assign tmo_expired = (tmo_q == TIMEOUT_CYCLES - 1);
`endif

   assign press = button & ~btn_q;
   assign mark  = turn_q ? 2'b10 : 2'b01;

   // Per-cell occupancy and ownership by the player to move, then line ownership.
   always_comb begin
      occupied = '0;
      owned    = '0;
      for (int i = 0; i < 9; i++) begin
         occupied[i] = |board_q[2*i +: 2];
         owned[i]    = (board_q[2*i +: 2] == mark);
      end
      lines[0]  = &owned[2:0];
      lines[1]  = &owned[5:3];
      lines[2]  = &owned[8:6];
      lines[3]  = owned[0] & owned[3] & owned[6];
      lines[4]  = owned[1] & owned[4] & owned[7];
      lines[5]  = owned[2] & owned[5] & owned[8];
      lines[6]  = owned[0] & owned[4] & owned[8];
      lines[7]  = owned[2] & owned[4] & owned[6];
      sel_valid = ($countones(sel_q) == 1) && ((sel_q & occupied) == 9'd0);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      board_d  = board_q;
      turn_d   = turn_q;
      status_d = status_q;
      win_d    = win_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      unique case (state_q)
         st_idle: begin
            if (press) begin
               sel_d   = switches;
               state_d = st_validate;
            end
`ifdef GAME_SEQ_TIMEOUT_EN
            else if (tmo_expired) begin
               turn_d = ~turn_q;
            end
`endif
         end
         st_validate: begin
            if (sel_valid) begin
               state_d = st_commit;
            end else begin
               err_d   = 1'b1;
               state_d = st_idle;
            end
         end
         st_commit: begin
            for (int i = 0; i < 9; i++) begin
               if (sel_q[i]) board_d[2*i +: 2] = mark;
            end
            cnt_d   = cnt_q + 4'd1;
            state_d = st_check;
         end
         st_check: begin
            win_d = lines;
            if (|lines) begin
               status_d = turn_q ? 2'b10 : 2'b01;
               state_d  = st_over;
            end else if (cnt_q == 4'd9) begin
               status_d = 2'b11;
               state_d  = st_over;
            end else begin
               turn_d  = ~turn_q;
               state_d = st_idle;
            end
         end
         st_over: begin
            if (press) begin
               board_d  = '0;
               win_d    = '0;
               cnt_d    = '0;
               status_d = '0;
               turn_d   = 1'b0;
               state_d  = st_idle;
            end
         end
         default: state_d = st_idle;
      endcase
      busy_d = (state_d != st_idle) && (state_d != st_over);
   end

`ifdef GAME_SEQ_TIMEOUT_EN
   // Idle timer: counts only while staying in IDLE; clears on expiry, exit and entry.
   always_comb begin
      tmo_d = '0;
      if (state_q == st_idle && state_d == st_idle && !tmo_expired) begin
         tmo_d = tmo_q + 32'd1;
      end
   end

   // Idle timer register.
   always_ff @(posedge clk) begin
      if (rst) tmo_q <= '0;
      else     tmo_q <= tmo_d;
   end
`endif

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= st_idle;
         btn_q    <= 1'b0;
         sel_q    <= '0;
         board_q  <= '0;
         turn_q   <= 1'b0;
         status_q <= '0;
         win_q    <= '0;
         cnt_q    <= '0;
         move_err <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         btn_q    <= button;
         sel_q    <= sel_d;
         board_q  <= board_d;
         turn_q   <= turn_d;
         status_q <= status_d;
         win_q    <= win_d;
         cnt_q    <= cnt_d;
         move_err <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign board      = board_q;
   assign turn       = turn_q;
   assign status     = status_q;
   assign win_line   = win_q;
   assign move_count = cnt_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: table-driven directed bench for game_sequencer plus hand-written
// sequences for timing, held-button restart, draw, 9th-move win and the idle timeout.
module tb_game_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        button = 1'b0;
   logic [8:0]  switches = '0;
   logic [17:0] board;
   logic        turn;
   logic [1:0]  status;
   logic [7:0]  win_line;
   logic [3:0]  move_count;
   logic        move_err;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   game_sequencer #(.TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .button     (button),
      .switches   (switches),
      .board      (board),
      .turn       (turn),
      .status     (status),
      .win_line   (win_line),
      .move_count (move_count),
      .move_err   (move_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0]  sw;
      int          err;
      logic [17:0] brd;
      logic        trn;
      logic [1:0]  st;
      logic [7:0]  win;
      logic [3:0]  cnt;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One press of sw, then enough cycles for the move to settle; counts move_err cycles.
   task automatic press_move(input logic [8:0] sw, output int errs);
      errs = 0;
      @(negedge clk);
      switches = sw;
      button   = 1'b1;
      @(negedge clk);
      button   = 1'b0;
      switches = ~sw;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (move_err) errs++;
      end
   endtask

   task automatic chk_state(input string tag, input logic [17:0] b, input logic t,
                            input logic [1:0] s, input logic [7:0] w, input logic [3:0] c);
      chk({tag, ".board"}, 32'(board), 32'(b));
      chk({tag, ".turn"}, 32'(turn), 32'(t));
      chk({tag, ".status"}, 32'(status), 32'(s));
      chk({tag, ".win_line"}, 32'(win_line), 32'(w));
      chk({tag, ".move_count"}, 32'(move_count), 32'(c));
   endtask

   initial begin
      int errs;
      logic [8:0] seq[9];

      vecs[0]  = '{9'h003, 1, 18'h00000, 1'b0, 2'b00, 8'h00, 4'd0};
      vecs[1]  = '{9'h000, 1, 18'h00000, 1'b0, 2'b00, 8'h00, 4'd0};
      vecs[2]  = '{9'h010, 0, 18'h00100, 1'b1, 2'b00, 8'h00, 4'd1};
      vecs[3]  = '{9'h010, 1, 18'h00100, 1'b1, 2'b00, 8'h00, 4'd1};
      vecs[4]  = '{9'h008, 0, 18'h00180, 1'b0, 2'b00, 8'h00, 4'd2};
      vecs[5]  = '{9'h001, 0, 18'h00181, 1'b1, 2'b00, 8'h00, 4'd3};
      vecs[6]  = '{9'h040, 0, 18'h02181, 1'b0, 2'b00, 8'h00, 4'd4};
      vecs[7]  = '{9'h002, 0, 18'h02185, 1'b1, 2'b00, 8'h00, 4'd5};
      vecs[8]  = '{9'h080, 0, 18'h0A185, 1'b0, 2'b00, 8'h00, 4'd6};
      vecs[9]  = '{9'h004, 0, 18'h0A195, 1'b0, 2'b01, 8'h01, 4'd7};
      vecs[10] = '{9'h100, 0, 18'h00000, 1'b0, 2'b00, 8'h00, 4'd0};
      vecs[11] = '{9'h001, 0, 18'h00001, 1'b1, 2'b00, 8'h00, 4'd1};
      vecs[12] = '{9'h008, 0, 18'h00081, 1'b0, 2'b00, 8'h00, 4'd2};
      vecs[13] = '{9'h002, 0, 18'h00085, 1'b1, 2'b00, 8'h00, 4'd3};
      vecs[14] = '{9'h010, 0, 18'h00285, 1'b0, 2'b00, 8'h00, 4'd4};
      vecs[15] = '{9'h004, 0, 18'h00295, 1'b0, 2'b01, 8'h01, 4'd5};
      vecs[16] = '{9'h1FF, 0, 18'h00000, 1'b0, 2'b00, 8'h00, 4'd0};

      do_reset();
      chk_state("reset", 18'h0, 1'b0, 2'b00, 8'h00, 4'd0);
      chk("reset.move_err", 32'(move_err), 32'd0);
      chk("reset.busy", 32'(busy), 32'd0);

      for (int v = 0; v < 17; v++) begin
         press_move(vecs[v].sw, errs);
         chk($sformatf("vec%0d.err_cycles", v), 32'(errs), 32'(vecs[v].err));
         chk_state($sformatf("vec%0d", v), vecs[v].brd, vecs[v].trn, vecs[v].st,
                   vecs[v].win, vecs[v].cnt);
      end

      // Win on the 9th move completing both diagonals at once.
      seq = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h040, 9'h020, 9'h100, 9'h080, 9'h010};
      for (int m = 0; m < 9; m++) press_move(seq[m], errs);
      chk_state("win9", 18'h19999, 1'b0, 2'b01, 8'hC0, 4'd9);
      press_move(9'h000, errs);
      chk_state("win9_restart", 18'h0, 1'b0, 2'b00, 8'h00, 4'd0);

      // Draw: squares 0,1,2,4,3,5,7,6,8.
      seq = '{9'h001, 9'h002, 9'h004, 9'h010, 9'h008, 9'h020, 9'h080, 9'h040, 9'h100};
      for (int m = 0; m < 9; m++) press_move(seq[m], errs);
      chk_state("draw", 18'h16A59, 1'b0, 2'b11, 8'h00, 4'd9);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         switches = 9'(k * 37);
      end
      chk_state("draw_hold", 18'h16A59, 1'b0, 2'b11, 8'h00, 4'd9);

      // Restart with the button held for 10 cycles: one restart, no move.
      @(negedge clk);
      switches = 9'h001;
      button   = 1'b1;
      for (int k = 0; k < 10; k++) @(negedge clk);
      chk_state("held_restart", 18'h0, 1'b0, 2'b00, 8'h00, 4'd0);
      chk("held_restart.busy", 32'(busy), 32'd0);
      button = 1'b0;
      repeat (3) @(negedge clk);
      chk("held_release.move_count", 32'(move_count), 32'd0);
      press_move(9'h001, errs);
      chk_state("fresh_press", 18'h00001, 1'b1, 2'b00, 8'h00, 4'd1);

      // Cycle-accurate move timing; a press during COMMIT is ignored.
      @(negedge clk);
      switches = 9'h100;
      button   = 1'b1;
      @(negedge clk);
      chk("t1.busy", 32'(busy), 32'd1);
      chk("t1.board", 32'(board), 32'h00001);
      button = 1'b0;
      @(negedge clk);
      chk("t2.board", 32'(board), 32'h00001);
      switches = 9'h002;
      button   = 1'b1;
      @(negedge clk);
      chk("t3.board", 32'(board), 32'h20001);
      chk("t3.turn", 32'(turn), 32'd1);
      button = 1'b0;
      @(negedge clk);
      chk("t4.turn", 32'(turn), 32'd0);
      chk("t4.busy", 32'(busy), 32'd0);
      repeat (6) @(negedge clk);
      chk_state("busy_press_ignored", 18'h20001, 1'b0, 2'b00, 8'h00, 4'd2);

      // Idle timeout.
      do_reset();
`ifdef GAME_SEQ_TIMEOUT_EN
      repeat (15) @(negedge clk);
      chk("tmo15.turn", 32'(turn), 32'd0);
      @(negedge clk);
      chk("tmo16.turn", 32'(turn), 32'd1);
      chk("tmo16.board", 32'(board), 32'd0);
      repeat (5) @(negedge clk);
      do_reset();
      chk("tmo_rst.turn", 32'(turn), 32'd0);
      repeat (15) @(negedge clk);
      chk("tmo_rst15.turn", 32'(turn), 32'd0);
      @(negedge clk);
      chk("tmo_rst16.turn", 32'(turn), 32'd1);
`else
      repeat (40) @(negedge clk);
      chk("no_tmo.turn", 32'(turn), 32'd0);
      chk("no_tmo.board", 32'(board), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
